d_ram_arb: RTL and testbench
============================

# d_ram_arb

Two-requester arbiter that shares the single data RAM (`d_ram`: one write port, one registered read port, 1-cycle read latency) between the CPU load/store unit and the DMA engine. One access per cycle: the block selects a requester, drives the RAM write or read port, and routes the returned read data to the owner with a registered valid. The CPU has fixed priority, and a wait counter guarantees the DMA a grant after bounded starvation.

## Interface
- `addr_width`, 12, RAM address width; must match `d_ram`.
- `data_width`, 8, RAM data width; must match `d_ram`.
- `max_wait`, 4, consecutive cycles the DMA may wait before it wins priority; legal range is 1 or more.

- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cpu_req` input 1: CPU access request.
- `cpu_we` input 1: 1 = write, 0 = read.
- `cpu_addr` input addr_width: CPU address.
- `cpu_wdata` input data_width: CPU write data.
- `cpu_gnt` output 1: combinational; the access completes on this edge.
- `cpu_rvalid` output 1: registered; `cpu_rdata` is valid this cycle.
- `cpu_rdata` output data_width: read data, equal to `ram_dout`.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same as the CPU port, for the DMA.
- `ram_w_en` output 1: drives `d_ram` `w_en`.
- `ram_w_addr` output addr_width: drives `d_ram` `w_addr`.
- `ram_din` output data_width: drives `d_ram` `din`.
- `ram_r_en` output 1: drives `d_ram` `r_en`.
- `ram_r_addr` output addr_width: drives `d_ram` `r_addr`.
- `ram_dout` input data_width: from `d_ram` `dout`.

## Operation
- **Selection** (combinational, each cycle):
  - `dma_pri` = (`wait_cnt` == `max_wait`).
  - If `dma_pri` and `dma_req`, grant the DMA.
  - Otherwise, if `cpu_req`, grant the CPU.
  - Otherwise, if `dma_req`, grant the DMA.
  - Otherwise, no grant.
- **Exclusivity**: at most one `*_gnt` is high in any cycle. Both are 0 while `rst_n` = 0.
- **Request holding**: a requester holds req, we, addr and wdata stable until it sees gnt. It may drop req only after a grant.
- **Granted write**: `ram_w_en` = 1, `ram_w_addr`/`ram_din` = the winner's addr/wdata, `ram_r_en` = 0.
- **Granted read**: `ram_r_en` = 1, `ram_r_addr` = the winner's addr, `ram_w_en` = 0.
- **No grant**: `ram_w_en` = `ram_r_en` = 0. Address and data outputs follow the CPU inputs, so the values are don't-care.
- **Read owner**: a register `rd_owner` ∈ {NONE, CPU, DMA}. On each edge it loads the owner of the granted read, or NONE if there was no granted read.
  - `cpu_rvalid` = (`rd_owner` == CPU); `dma_rvalid` = (`rd_owner` == DMA).
  - Both `*_rdata` outputs are wired to `ram_dout`. Consumers qualify the data with their rvalid only.
- **Wait counter** (`wait_cnt`, width $clog2(`max_wait`+1)):
  - Clears to 0 when `dma_gnt` is high or `dma_req` is low.
  - Otherwise increments, saturating at `max_wait`.
- **Back-to-back**: one requester may be granted on consecutive cycles. A read followed by a write, or a write followed by a read, needs no bubble.
- **Same-address write-then-read** on consecutive grants: the read returns the newly written data, because the write lands before the read edge.
- **Reset**:
  - Asserting `rst_n` low at any time immediately forces `rd_owner` = NONE and `wait_cnt` = 0.
  - The gnt, rvalid, `ram_w_en` and `ram_r_en` outputs all go to 0.
  - An in-flight read's rvalid is dropped and never delivered.
  - The RAM contents are not affected.

## Timing
- Grant latency is 0 cycles: gnt rises in the same cycle as req if that requester wins. Handshake completion is the edge where req and gnt are both high.
- Write data is committed to the RAM at that edge.
- Read latency is 1 cycle: rvalid and rdata are valid in the cycle after the grant edge, for exactly 1 cycle per granted read.
- Worst-case DMA wait under continuous CPU requests is `max_wait` cycles. The grant comes in cycle `max_wait`+1, counting from the first cycle `dma_req` is high.
- Reset values: `cpu_gnt` = `dma_gnt` = `cpu_rvalid` = `dma_rvalid` = `ram_w_en` = `ram_r_en` = 0, `wait_cnt` = 0, `rd_owner` = NONE.

## Test plan
- **CPU write then read:**
  - Stimulus: CPU writes 0xA5 to 0x123, then reads 0x123 on the next cycle, with DMA idle.
  - Response: `cpu_gnt` is high in both cycles, and `cpu_rvalid` = 1 with `cpu_rdata` = 0xA5 one cycle after the read grant. `dma_rvalid` stays 0.
- **Simultaneous requests:**
  - Stimulus: `cpu_req` and `dma_req` rise together; the CPU reads 0x010, the DMA reads 0x020 (preloaded with 0x11 and 0x22). The CPU then drops req after its grant.
  - Response: the CPU is granted in cycle 0 and the DMA in cycle 1. `cpu_rdata` = 0x11 in cycle 1 and `dma_rdata` = 0x22 in cycle 2.
- **Starvation bound:**
  - Stimulus: `cpu_req` held high continuously, `dma_req` high from cycle 0, `max_wait` = 4.
  - Response: `cpu_gnt` is high in cycles 0–3, and `dma_gnt` is high only in cycle 4. `wait_cnt` is 0 in cycle 5, and the CPU is granted again in cycle 5.
- **DMA write burst with idle CPU:**
  - Stimulus: the DMA writes 0x00..0x07 to addresses 0x800..0x807 on consecutive cycles.
  - Response: `dma_gnt` is high every cycle and `ram_w_en` is high for 8 cycles. A later CPU readback of 0x805 returns 0x05.
- **Reset mid-read:**
  - Stimulus: the CPU is granted a read of 0x040, and `rst_n` falls 0.5 cycle after the grant edge.
  - Response: `cpu_rvalid` is 0 immediately and stays 0. After release, the first request is granted normally with `wait_cnt` = 0.
- **Exclusivity check:**
  - Stimulus: 10k cycles of random req, we and addr on both ports.
  - Response: `cpu_gnt` and `dma_gnt` are never both 1, and `ram_w_en` and `ram_r_en` are never both 1. Each granted read yields exactly one rvalid, on the correct port, with data matching a reference memory model. No DMA wait exceeds 4 cycles.

Source files
------------

// File: rtl/d_ram_arb_if.sv
// Bundle between the CPU/DMA requesters, the d_ram_arb arbiter and the d_ram ports.
// slave is the arbiter view; master is the requester/RAM-side view.
interface d_ram_arb_if #(
  parameter int addr_width = 12,
  parameter int data_width = 8
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [addr_width-1:0] cpu_addr;
  logic [data_width-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [data_width-1:0] cpu_rdata;

  logic                  dma_req;
  logic                  dma_we;
  logic [addr_width-1:0] dma_addr;
  logic [data_width-1:0] dma_wdata;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [data_width-1:0] dma_rdata;

  logic                  ram_w_en;
  logic [addr_width-1:0] ram_w_addr;
  logic [data_width-1:0] ram_din;
  logic                  ram_r_en;
  logic [addr_width-1:0] ram_r_addr;
  logic [data_width-1:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_w_en, ram_w_addr, ram_din, ram_r_en, ram_r_addr
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_w_en, ram_w_addr, ram_din, ram_r_en, ram_r_addr
  );
endinterface

// File: rtl/d_ram_arb.sv
// CPU/DMA arbiter for the single-port-pair data RAM: CPU has fixed priority,
// a saturating wait counter hands the DMA priority after max_wait starved cycles.
//
// rd_owner state | meaning
// OWN_NONE       | no read returns this cycle
// OWN_CPU        | ram_dout belongs to the CPU this cycle
// OWN_DMA        | ram_dout belongs to the DMA this cycle
module d_ram_arb #(
  parameter int addr_width = 12,
  parameter int data_width = 8,
  parameter int max_wait   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  d_ram_arb_if.slave   bus
);
  localparam int cnt_w = $clog2(max_wait + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e                rd_owner_q, rd_owner_d;
  logic [cnt_w-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  dma_pri;
  logic                  cpu_win;
  logic                  dma_win;
  logic                  sel_we;
  logic [addr_width-1:0] sel_addr;
  logic [data_width-1:0] sel_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    dma_pri    = (wait_cnt_q == cnt_w'(max_wait));
    // Grants are gated by rst_n so nothing completes while reset is held.
    dma_win    = rst_n & bus.dma_req & (dma_pri | ~bus.cpu_req);
    cpu_win    = rst_n & bus.cpu_req & ~dma_win;

    sel_we     = dma_win ? bus.dma_we    : bus.cpu_we;
    sel_addr   = dma_win ? bus.dma_addr  : bus.cpu_addr;
    sel_wdata  = dma_win ? bus.dma_wdata : bus.cpu_wdata;

    rd_owner_d = OWN_NONE;
    if (cpu_win && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_win && !bus.dma_we) begin
      rd_owner_d = OWN_DMA;
    end

    wait_cnt_d = wait_cnt_q;
    if (dma_win || !bus.dma_req) begin
      wait_cnt_d = '0;
    end else if (!dma_pri) begin
      wait_cnt_d = wait_cnt_q + cnt_w'(1);
    end
  end

  assign bus.cpu_gnt    = cpu_win;
  assign bus.dma_gnt    = dma_win;

  assign bus.ram_w_en   = (cpu_win | dma_win) & sel_we;
  assign bus.ram_r_en   = (cpu_win | dma_win) & ~sel_we;
  assign bus.ram_w_addr = sel_addr;
  assign bus.ram_r_addr = sel_addr;
  assign bus.ram_din    = sel_wdata;

  assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
  assign bus.cpu_rdata  = bus.ram_dout;
  assign bus.dma_rdata  = bus.ram_dout;
endmodule

// File: tb/tb_d_ram_arb.sv
// Directed and randomized bench for d_ram_arb with a behavioural d_ram and a
// reference model of the arbitration rules and memory contents.
module tb_d_ram_arb;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int MAXW = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  d_ram_arb_if #(.addr_width(AW), .data_width(DW)) bus ();

  d_ram_arb #(.addr_width(AW), .data_width(DW), .max_wait(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural d_ram: write at the edge, registered read with 1-cycle latency.
  logic [DW-1:0] ram [4096];
  always @(posedge clk) begin
    if (bus.ram_w_en) ram[bus.ram_w_addr] <= bus.ram_din;
    if (bus.ram_r_en) bus.ram_dout <= ram[bus.ram_r_addr];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [4096];
  bit            known   [4096];
  int            dwait;
  bit            cpend, dpend;
  bit            exp_crv, exp_drv, exp_known;
  logic [DW-1:0] exp_data;
  bit            exp_cg, exp_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma_drive(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ram_dout = '0;
    // Request held during reset must not be granted.
    cpu_drive(1'b1, 1'b1, 12'h555, 8'h33);
    dma_drive(1'b1, 1'b0, 12'h666, 8'h00);
    #12;
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
    chk("rst_dma_gnt", 32'(bus.dma_gnt), 0);
    chk("rst_w_en", 32'(bus.ram_w_en), 0);
    chk("rst_r_en", 32'(bus.ram_r_en), 0);
    chk("rst_rvalid", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 0);
    chk("rst_wait", 32'(dut.wait_cnt_q), 0);
    cpu_drive(1'b0, 1'b0, '0, '0);
    dma_drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // CPU write then read of the same address.
    cyc();
    cpu_drive(1'b1, 1'b1, 12'h123, 8'hA5);
    #2;
    chk("t1_wr_gnt", 32'(bus.cpu_gnt), 1);
    chk("t1_w_en", 32'(bus.ram_w_en), 1);
    chk("t1_w_addr", 32'(bus.ram_w_addr), 32'h123);
    chk("t1_din", 32'(bus.ram_din), 32'hA5);
    cyc();
    cpu_drive(1'b1, 1'b0, 12'h123, 8'h00);
    #2;
    chk("t1_rd_gnt", 32'(bus.cpu_gnt), 1);
    chk("t1_r_en", 32'(bus.ram_r_en), 1);
    chk("t1_w_en_lo", 32'(bus.ram_w_en), 0);
    cyc();
    cpu_drive(1'b0, 1'b0, '0, '0);
    #2;
    chk("t1_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("t1_rdata", 32'(bus.cpu_rdata), 32'hA5);
    chk("t1_dma_rvalid", 32'(bus.dma_rvalid), 0);

    // Preload then simultaneous reads.
    cyc();
    cpu_drive(1'b1, 1'b1, 12'h010, 8'h11);
    cyc();
    cpu_drive(1'b1, 1'b1, 12'h020, 8'h22);
    cyc();
    cpu_drive(1'b1, 1'b0, 12'h010, 8'h00);
    dma_drive(1'b1, 1'b0, 12'h020, 8'h00);
    #2;
    chk("t2_c0_cpu_gnt", 32'(bus.cpu_gnt), 1);
    chk("t2_c0_dma_gnt", 32'(bus.dma_gnt), 0);
    cyc();
    cpu_drive(1'b0, 1'b0, '0, '0);
    #2;
    chk("t2_c1_dma_gnt", 32'(bus.dma_gnt), 1);
    chk("t2_c1_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("t2_c1_cpu_rdata", 32'(bus.cpu_rdata), 32'h11);
    cyc();
    dma_drive(1'b0, 1'b0, '0, '0);
    #2;
    chk("t2_c2_dma_rvalid", 32'(bus.dma_rvalid), 1);
    chk("t2_c2_dma_rdata", 32'(bus.dma_rdata), 32'h22);
    chk("t2_c2_cpu_rvalid", 32'(bus.cpu_rvalid), 0);

    // Starvation bound under continuous CPU requests.
    for (int c = 0; c < 6; c++) begin
      cyc();
      cpu_drive(1'b1, 1'b0, 12'h010, 8'h00);
      if (c < 5) dma_drive(1'b1, 1'b1, 12'h0F0, 8'h77);
      else       dma_drive(1'b0, 1'b0, '0, '0);
      #2;
      chk($sformatf("t3_cpu_gnt_c%0d", c), 32'(bus.cpu_gnt), (c == 4) ? 0 : 1);
      chk($sformatf("t3_dma_gnt_c%0d", c), 32'(bus.dma_gnt), (c == 4) ? 1 : 0);
      if (c == 4) chk("t3_wait_c4", 32'(dut.wait_cnt_q), MAXW);
      if (c == 5) chk("t3_wait_c5", 32'(dut.wait_cnt_q), 0);
    end
    cyc();
    cpu_drive(1'b0, 1'b0, '0, '0);

    // DMA write burst with the CPU idle.
    for (int i = 0; i < 8; i++) begin
      dma_drive(1'b1, 1'b1, 12'(12'h800 + i), 8'(i));
      #2;
      chk($sformatf("t4_dma_gnt_%0d", i), 32'(bus.dma_gnt), 1);
      chk($sformatf("t4_w_en_%0d", i), 32'(bus.ram_w_en), 1);
      cyc();
    end
    dma_drive(1'b0, 1'b0, '0, '0);
    cpu_drive(1'b1, 1'b0, 12'h805, 8'h00);
    cyc();
    cpu_drive(1'b0, 1'b0, '0, '0);
    #2;
    chk("t4_rb_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("t4_rb_rdata", 32'(bus.cpu_rdata), 32'h05);

    // Reset falls half a cycle after a CPU read grant, with the DMA starving.
    cyc();
    cpu_drive(1'b1, 1'b0, 12'h040, 8'h00);
    dma_drive(1'b1, 1'b1, 12'h0F1, 8'h99);
    #2;
    chk("t5_gnt", 32'(bus.cpu_gnt), 1);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid_now", 32'(bus.cpu_rvalid), 0);
    chk("t5_gnt_rst", 32'({bus.cpu_gnt, bus.dma_gnt}), 0);
    chk("t5_wait_rst", 32'(dut.wait_cnt_q), 0);
    cpu_drive(1'b0, 1'b0, '0, '0);
    dma_drive(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #5;
    rst_n = 1'b1;
    cyc();
    #2;
    chk("t5_rvalid_after", 32'(bus.cpu_rvalid), 0);
    cyc();
    cpu_drive(1'b1, 1'b0, 12'h123, 8'h00);
    dma_drive(1'b1, 1'b1, 12'h0F2, 8'h44);
    #2;
    chk("t5_wait_rel", 32'(dut.wait_cnt_q), 0);
    chk("t5_cpu_first", 32'(bus.cpu_gnt), 1);
    chk("t5_dma_first", 32'(bus.dma_gnt), 0);
    cyc();
    cpu_drive(1'b0, 1'b0, '0, '0);
    #2;
    chk("t5_rdata", 32'(bus.cpu_rdata), 32'hA5);
    chk("t5_dma_next", 32'(bus.dma_gnt), 1);
    cyc();
    dma_drive(1'b0, 1'b0, '0, '0);

    // Randomized traffic against the reference model.
    dwait = 0; cpend = 0; dpend = 0;
    exp_crv = 0; exp_drv = 0; exp_known = 0; exp_data = '0;
    for (int n = 0; n < 10000; n++) begin
      cyc();
      if (!cpend && $urandom_range(0, 99) < 60) begin
        cpend = 1;
        cpu_drive(1'b1, 1'($urandom_range(0, 1)), 12'(12'h300 + $urandom_range(0, 15)), 8'($urandom));
      end else if (!cpend) begin
        bus.cpu_req = 1'b0;
      end
      if (!dpend && $urandom_range(0, 99) < 50) begin
        dpend = 1;
        dma_drive(1'b1, 1'($urandom_range(0, 1)), 12'(12'h300 + $urandom_range(0, 15)), 8'($urandom));
      end else if (!dpend) begin
        bus.dma_req = 1'b0;
      end
      #2;
      exp_dg = dpend && (dwait >= MAXW || !cpend);
      exp_cg = cpend && !exp_dg;
      chk("rnd_cpu_gnt", 32'(bus.cpu_gnt), 32'(exp_cg));
      chk("rnd_dma_gnt", 32'(bus.dma_gnt), 32'(exp_dg));
      chk("rnd_excl_gnt", 32'(bus.cpu_gnt & bus.dma_gnt), 0);
      chk("rnd_excl_en", 32'(bus.ram_w_en & bus.ram_r_en), 0);
      chk("rnd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_crv));
      chk("rnd_dma_rvalid", 32'(bus.dma_rvalid), 32'(exp_drv));
      if ((exp_crv || exp_drv) && exp_known)
        chk("rnd_rdata", 32'(exp_crv ? bus.cpu_rdata : bus.dma_rdata), 32'(exp_data));

      exp_crv = 0; exp_drv = 0;
      if (exp_cg || exp_dg) begin
        if (exp_cg ? bus.cpu_we : bus.dma_we) begin
          ref_mem[exp_cg ? bus.cpu_addr : bus.dma_addr] = exp_cg ? bus.cpu_wdata : bus.dma_wdata;
          known[exp_cg ? bus.cpu_addr : bus.dma_addr]   = 1'b1;
        end else begin
          exp_crv   = exp_cg;
          exp_drv   = exp_dg;
          exp_data  = ref_mem[exp_cg ? bus.cpu_addr : bus.dma_addr];
          exp_known = known[exp_cg ? bus.cpu_addr : bus.dma_addr];
        end
      end
      if (dpend && !exp_dg) dwait++;
      else dwait = 0;
      chk("rnd_dma_wait_bound", 32'(dwait <= MAXW), 1);
      if (exp_cg) cpend = 0;
      if (exp_dg) dpend = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
